uart_rx: RTL and testbench

UART receiver: deserialises one 8N1 byte from the serial RX line into a parallel holding register. It counterparts the existing UART transmit path and includes its own oversampling baud generator. The host side reads the byte through an unload strobe and empty flag, mirroring the transmitter's load/empty handshake. It sits between the FPGA RX pin and board switches/LEDs or user logic.

---
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 UART receiver with 16x oversampling, holding register and
//           unload/empty handshake plus sticky frame-error and overrun flags.
// Rev     : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_enable,
    input  logic       uld_rx_data,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                  c_DIV      = CLK_FREQ / (BAUD * 16);
    localparam int                  c_CNT_W    = $clog2(c_DIV);
    localparam logic [c_CNT_W-1:0]  c_TICK_MAX = c_CNT_W'(c_DIV - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_DATA  = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_BREAK = 3'd4;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [c_CNT_W-1:0] r_tick_cnt;
    logic               w_tick;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [3:0]         r_s;
    logic [3:0]         w_s_nxt;
    logic [2:0]         r_b;
    logic [2:0]         w_b_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_commit;
    logic               w_ferr_set;
    logic               r_uld_d;
    logic               w_uld_rise;
    logic [7:0]         r_rx_data;
    logic               r_rx_empty;
    logic               r_frame_err;
    logic               r_overrun;

    // Synchroniser resets to the idle line level so release never looks like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_s     <= 4'd0;
            r_b     <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_b     <= w_b_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_b_nxt     = r_b;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        w_ferr_set  = 1'b0;
        if (!rx_enable) begin
            w_state_nxt = c_S_IDLE;
            w_s_nxt     = 4'd0;
            w_b_nxt     = 3'd0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_tick && !r_rx_s) begin
                        w_state_nxt = c_S_START;
                        w_s_nxt     = 4'd0;
                    end
                end
                c_S_START: begin
                    if (w_tick) begin
                        if (r_s == 4'd7) begin
                            w_s_nxt     = 4'd0;
                            w_b_nxt     = 3'd0;
                            w_state_nxt = r_rx_s ? c_S_IDLE : c_S_DATA;
                        end else begin
                            w_s_nxt = r_s + 4'd1;
                        end
                    end
                end
                c_S_DATA: begin
                    if (w_tick) begin
                        if (r_s == 4'd15) begin
                            w_shift_nxt = {r_rx_s, r_shift[7:1]};
                            w_s_nxt     = 4'd0;
                            if (r_b == 3'd7) begin
                                w_state_nxt = c_S_STOP;
                            end else begin
                                w_b_nxt = r_b + 3'd1;
                            end
                        end else begin
                            w_s_nxt = r_s + 4'd1;
                        end
                    end
                end
                c_S_STOP: begin
                    if (w_tick) begin
                        if (r_s == 4'd15) begin
                            w_s_nxt = 4'd0;
                            if (r_rx_s) begin
                                w_commit    = 1'b1;
                                w_state_nxt = c_S_IDLE;
                            end else begin
                                w_ferr_set  = 1'b1;
                                w_state_nxt = c_S_BREAK;
                            end
                        end else begin
                            w_s_nxt = r_s + 4'd1;
                        end
                    end
                end
                // A held-low line parks here until it returns high, at clk rate.
                c_S_BREAK: begin
                    if (r_rx_s) begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                end
            endcase
        end
    end

    assign w_uld_rise = uld_rx_data && !r_uld_d;

    // A commit coinciding with an unload edge wins, but still clears the sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_uld_d     <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_empty  <= 1'b1;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_uld_d <= uld_rx_data;
            if (w_commit) begin
                r_rx_data  <= r_shift;
                r_rx_empty <= 1'b0;
                r_overrun  <= w_uld_rise ? 1'b0 : (r_overrun | !r_rx_empty);
                if (w_uld_rise) begin
                    r_frame_err <= 1'b0;
                end
            end else if (w_uld_rise) begin
                r_rx_empty  <= 1'b1;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_empty  = r_rx_empty;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed + random frames for uart_rx, checked against a
//           holding-register model driven by the UART protocol rules.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_CLK_FREQ = 1600000;
    localparam int c_BAUD     = 10000;
    localparam int c_BIT      = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_enable;
    logic       uld_rx_data;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int fall_cyc  = 0;

    // Reference holding-register state
    logic [7:0] m_data;
    logic       m_empty;
    logic       m_ferr;
    logic       m_ovr;

    uart_rx #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .rx_enable   (rx_enable),
        .uld_rx_data (uld_rx_data),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rx_empty) fall_cyc = cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  {24'd0, rx_data}, {24'd0, m_data});
        check({tag, ".empty"}, {31'd0, rx_empty}, {31'd0, m_empty});
        check({tag, ".ferr"},  {31'd0, frame_err}, {31'd0, m_ferr});
        check({tag, ".ovr"},   {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives start, 8 data bits LSB first, and the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx_in     = 1'b0;
        start_cyc = cyc;
        clks(c_BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            clks(c_BIT);
        end
        rx_in = stop;
        clks(c_BIT);
    endtask

    task automatic rx_valid(input logic [7:0] d, input string tag);
        logic pre_empty;
        int   lat;
        pre_empty = m_empty;
        send_frame(d, 1'b1);
        clks(20);
        if (!m_empty) m_ovr = 1'b1;
        m_data  = d;
        m_empty = 1'b0;
        check_all(tag);
        if (pre_empty) begin
            lat = fall_cyc - start_cyc;
            n_checks++;
            assert (lat >= 1515 && lat <= 1540) else begin
                n_err++;
                $error("FAIL %s.latency observed=%0d expected=1515..1540", tag, lat);
            end
        end
    endtask

    task automatic unload(input string tag);
        @(negedge clk);
        uld_rx_data = 1'b1;
        clks(3);
        uld_rx_data = 1'b0;
        clks(2);
        m_empty = 1'b1;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_empty = 1'b1;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        reset       = 1'b0;
        rx_in       = 1'b1;
        rx_enable   = 1'b0;
        uld_rx_data = 1'b0;
        model_reset();

        // 1: reset state, then long idle
        clks(5);
        check_all("rst");
        reset = 1'b1;
        clks(2000);
        check_all("idle");

        // 2: single byte and unload
        rx_enable = 1'b1;
        clks(10);
        rx_valid(8'h6C, "b6c");
        unload("uld6c");

        // 3: overrun
        rx_valid(8'hA5, "ba5");
        rx_valid(8'h3C, "b3c");
        unload("uld3c");

        // 4: framing error, held-low break, then recovery
        send_frame(8'hFF, 1'b0);
        clks(3 * c_BIT);
        rx_in = 1'b1;
        clks(200);
        m_ferr = 1'b1;
        check_all("ferr");
        rx_valid(8'h55, "b55");
        unload("uld55");

        // 5: glitch rejection and enable drop mid-frame
        @(negedge clk);
        rx_in = 1'b0;
        clks(40);
        rx_in = 1'b1;
        clks(400);
        check_all("glitch");
        @(negedge clk);
        rx_in = 1'b0;
        clks(c_BIT);
        d = 8'h81;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) rx_enable = 1'b0;
            rx_in = d[i];
            clks(c_BIT);
        end
        rx_in = 1'b1;
        clks(c_BIT + 50);
        rx_enable = 1'b1;
        clks(50);
        check_all("endrop");

        // Random frames with random unloads
        for (int k = 0; k < 6; k++) begin
            rx_valid(8'($urandom_range(0, 255)), "rnd");
            if ($urandom_range(0, 1) == 1) unload("rnduld");
        end

        // 6: async reset mid-frame with pending byte and overrun
        rx_valid(8'h12, "b12");
        rx_valid(8'h34, "b34");
        check({"pre_rst", ".ovr"}, {31'd0, overrun}, 32'd1);
        @(negedge clk);
        rx_in = 1'b0;
        clks(c_BIT);
        d = 8'h96;
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            if (i == 3) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_all("arst");
            end
            clks(c_BIT);
        end
        rx_in = 1'b1;
        clks(c_BIT + 20);
        check_all("arst_hold");
        reset = 1'b1;
        clks(50);
        rx_valid(8'hC3, "bc3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
